// File: rtl/mem_initiator.sv
// mem_initiator: load/store front end for a word-organised, byte-enabled RAM port.
// It takes one byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW request at a time and turns it
// into a single word access with lane selects and replicated write data. The read lane
// comes back sign- or zero-extended.
// Optional feature: define MEM_INITIATOR_MISALIGN_TRAP_EN to fault misaligned half/word
// accesses and reserved sizes. Without it, resp_err is tied low and the offsets are forced
// to alignment.
module mem_initiator #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_write,
   input  logic [1:0]        i_req_size,
   input  logic              i_req_unsigned,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [31:0]       i_req_wdata,
   output logic              o_resp_valid,
   output logic [31:0]       o_resp_rdata,
   output logic              o_resp_err,
   output logic [ADDR_W-3:0] o_mem_addr,
   output logic [3:0]        o_mem_sel,
   output logic [31:0]       o_mem_data_out,
   input  logic [31:0]       i_mem_data_in,
   output logic              o_mem_en,
   output logic              o_mem_write,
   input  logic              i_mem_ack
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

   state_e              r_state, w_state_next;
   logic                r_write;
   logic [1:0]          r_size;
   logic                r_unsigned;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic [31:0]         r_rdata;
   logic                w_accept;
   logic                w_fault;
   logic                w_busy;
   logic [1:0]          w_off;
   logic [3:0]          w_sel;
   logic [31:0]         w_dout;
   logic [7:0]          w_lane8;
   logic [15:0]         w_lane16;
   logic [31:0]         w_rdata;

   assign w_accept = i_req_valid && (r_state == StIdle);

`ifdef MEM_INITIATOR_MISALIGN_TRAP_EN
   logic r_err;
   assign w_fault = ((i_req_size == 2'd1) && i_req_addr[0])
                 || ((i_req_size == 2'd2) && (i_req_addr[1:0] != 2'b00))
                 || (i_req_size == 2'd3);
   assign o_resp_err = r_err;
`else
   assign w_fault    = 1'b0;
   assign o_resp_err = 1'b0;
`endif

   // Lane offset, selects, write data and load extraction from the captured request
   always_comb begin
      w_off    = 2'b00;
      w_sel    = 4'b1111;
      w_dout   = r_wdata;
      w_lane8  = 8'h00;
      w_lane16 = 16'h0000;
      w_rdata  = i_mem_data_in;
      unique case (r_size)
         2'd0: w_off = r_addr[1:0];
         2'd1: w_off = {r_addr[1], 1'b0};   // halves always land on an aligned pair
         default: w_off = 2'b00;            // word and reserved size act as word
      endcase
      unique case (w_off)
         2'd0: w_lane8 = i_mem_data_in[7:0];
         2'd1: w_lane8 = i_mem_data_in[15:8];
         2'd2: w_lane8 = i_mem_data_in[23:16];
         default: w_lane8 = i_mem_data_in[31:24];
      endcase
      w_lane16 = w_off[1] ? i_mem_data_in[31:16] : i_mem_data_in[15:0];
      unique case (r_size)
         2'd0: begin
            w_sel   = 4'b0001 << w_off;
            w_dout  = {4{r_wdata[7:0]}};
            w_rdata = {{24{~r_unsigned & w_lane8[7]}}, w_lane8};
         end
         2'd1: begin
            w_sel   = 4'b0011 << w_off;
            w_dout  = {2{r_wdata[15:0]}};
            w_rdata = {{16{~r_unsigned & w_lane16[15]}}, w_lane16};
         end
         default: begin
            w_sel   = 4'b1111;
            w_dout  = r_wdata;
            w_rdata = i_mem_data_in;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      w_state_next = r_state;
      o_req_ready  = 1'b0;
      o_mem_en     = 1'b0;
      o_resp_valid = 1'b0;
      unique case (r_state)
         StIdle: begin
            o_req_ready = 1'b1;
            if (i_req_valid) begin
               w_state_next = w_fault ? StResp : StReq;
            end
         end
         StReq: begin
            o_mem_en     = 1'b1;
            w_state_next = StWait;
         end
         StWait: begin
            if (i_mem_ack) begin
               w_state_next = StResp;
            end
         end
         default: begin
            o_resp_valid = 1'b1;
            w_state_next = StIdle;
         end
      endcase
   end

   // Bus outputs are only driven while an access is outstanding, and hold through WAIT
   assign w_busy         = (r_state == StReq) || (r_state == StWait);
   assign o_mem_addr     = w_busy ? r_addr[ADDR_W-1:2] : '0;
   assign o_mem_sel      = w_busy ? w_sel : 4'b0000;
   assign o_mem_data_out = w_busy ? w_dout : 32'h0;
   assign o_mem_write    = w_busy ? r_write : 1'b0;
   assign o_resp_rdata   = r_rdata;

   // Request capture on accept and response capture on acknowledge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_write    <= 1'b0;
         r_size     <= 2'd0;
         r_unsigned <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= 32'h0;
         r_rdata    <= 32'h0;
`ifdef MEM_INITIATOR_MISALIGN_TRAP_EN
         r_err      <= 1'b0;
`endif
      end else if (w_accept) begin
         r_write    <= i_req_write;
         r_size     <= i_req_size;
         r_unsigned <= i_req_unsigned;
         r_addr     <= i_req_addr;
         r_wdata    <= i_req_wdata;
         r_rdata    <= 32'h0;
`ifdef MEM_INITIATOR_MISALIGN_TRAP_EN
         r_err      <= w_fault;
`endif
      end else if ((r_state == StWait) && i_mem_ack) begin
         r_rdata    <= r_write ? 32'h0 : w_rdata;
      end
   end

endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: directed table of load/store vectors against a small byte-enabled
// RAM responder, plus hand sequences for a late ack with req_valid held, a reset during
// WAIT, and misaligned/reserved-size requests (build-dependent).
module tb_mem_initiator;

   logic        clk;
   logic        rst_n;
   logic        i_req_valid;
   logic        o_req_ready;
   logic        i_req_write;
   logic [1:0]  i_req_size;
   logic        i_req_unsigned;
   logic [9:0]  i_req_addr;
   logic [31:0] i_req_wdata;
   logic        o_resp_valid;
   logic [31:0] o_resp_rdata;
   logic        o_resp_err;
   logic [7:0]  o_mem_addr;
   logic [3:0]  o_mem_sel;
   logic [31:0] o_mem_data_out;
   logic [31:0] i_mem_data_in;
   logic        o_mem_en;
   logic        o_mem_write;
   logic        i_mem_ack;

   logic [31:0] ram [256];
   int          n_cmp;
   int          n_err;

   mem_initiator #(.ADDR_W(10)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_req_valid    (i_req_valid),
      .o_req_ready    (o_req_ready),
      .i_req_write    (i_req_write),
      .i_req_size     (i_req_size),
      .i_req_unsigned (i_req_unsigned),
      .i_req_addr     (i_req_addr),
      .i_req_wdata    (i_req_wdata),
      .o_resp_valid   (o_resp_valid),
      .o_resp_rdata   (o_resp_rdata),
      .o_resp_err     (o_resp_err),
      .o_mem_addr     (o_mem_addr),
      .o_mem_sel      (o_mem_sel),
      .o_mem_data_out (o_mem_data_out),
      .i_mem_data_in  (i_mem_data_in),
      .o_mem_en       (o_mem_en),
      .o_mem_write    (o_mem_write),
      .i_mem_ack      (i_mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [1:0]  sz;
      logic        un;
      logic [9:0]  addr;
      logic [31:0] wd;
      int          dly;
      logic [3:0]  sel;
      logic [31:0] dout;
      logic [31:0] rd;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One complete access; the bench plays the RAM responder with v.dly idle WAIT cycles
   task automatic access(input vec_t v, input logic hold);
      @(negedge clk);
      chk("ready_before", {31'b0, o_req_ready}, 32'd1);
      i_req_valid    = 1'b1;
      i_req_write    = v.wr;
      i_req_size     = v.sz;
      i_req_unsigned = v.un;
      i_req_addr     = v.addr;
      i_req_wdata    = v.wd;
      @(negedge clk);
      if (!hold) i_req_valid = 1'b0;
      chk("req_mem_en", {31'b0, o_mem_en}, 32'd1);
      chk("req_mem_write", {31'b0, o_mem_write}, {31'b0, v.wr});
      chk("req_mem_addr", {24'b0, o_mem_addr}, {24'b0, v.addr[9:2]});
      chk("req_mem_sel", {28'b0, o_mem_sel}, {28'b0, v.sel});
      chk("req_mem_dout", o_mem_data_out, v.dout);
      chk("req_ready_busy", {31'b0, o_req_ready}, 32'd0);
      chk("req_resp_valid", {31'b0, o_resp_valid}, 32'd0);
      for (int d = 0; d <= v.dly; d++) begin
         @(negedge clk);
         chk("wait_mem_en", {31'b0, o_mem_en}, 32'd0);
         chk("wait_sel_hold", {28'b0, o_mem_sel}, {28'b0, v.sel});
         chk("wait_addr_hold", {24'b0, o_mem_addr}, {24'b0, v.addr[9:2]});
         chk("wait_dout_hold", o_mem_data_out, v.dout);
         chk("wait_write_hold", {31'b0, o_mem_write}, {31'b0, v.wr});
         chk("wait_ready", {31'b0, o_req_ready}, 32'd0);
         chk("wait_resp_valid", {31'b0, o_resp_valid}, 32'd0);
         if (d == v.dly) begin
            i_mem_ack     = 1'b1;
            i_mem_data_in = ram[o_mem_addr];
            if (o_mem_write) begin
               for (int b = 0; b < 4; b++) begin
                  if (o_mem_sel[b]) ram[o_mem_addr][8*b +: 8] = o_mem_data_out[8*b +: 8];
               end
            end
         end else begin
            i_mem_ack     = 1'b0;
            i_mem_data_in = 32'h5A5A_C3C3;
         end
      end
      @(negedge clk);
      i_mem_ack     = 1'b0;
      i_mem_data_in = 32'h0;
      i_req_valid   = 1'b0;
      chk("resp_valid", {31'b0, o_resp_valid}, 32'd1);
      chk("resp_rdata", o_resp_rdata, v.rd);
      chk("resp_err", {31'b0, o_resp_err}, 32'd0);
      chk("resp_mem_en", {31'b0, o_mem_en}, 32'd0);
      @(negedge clk);
      chk("after_resp_valid", {31'b0, o_resp_valid}, 32'd0);
      chk("after_ready", {31'b0, o_req_ready}, 32'd1);
      chk("after_mem_en", {31'b0, o_mem_en}, 32'd0);
   endtask

   // Faulted request: response one cycle after accept, bus never strobed
   task automatic fault_access(input logic [1:0] sz, input logic [9:0] addr);
      @(negedge clk);
      i_req_valid    = 1'b1;
      i_req_write    = 1'b0;
      i_req_size     = sz;
      i_req_unsigned = 1'b0;
      i_req_addr     = addr;
      i_req_wdata    = 32'h0;
      @(negedge clk);
      i_req_valid = 1'b0;
      chk("fault_mem_en", {31'b0, o_mem_en}, 32'd0);
      chk("fault_resp_valid", {31'b0, o_resp_valid}, 32'd1);
      chk("fault_resp_err", {31'b0, o_resp_err}, 32'd1);
      chk("fault_rdata", o_resp_rdata, 32'h0);
      @(negedge clk);
      chk("fault_after_valid", {31'b0, o_resp_valid}, 32'd0);
      chk("fault_after_ready", {31'b0, o_req_ready}, 32'd1);
      chk("fault_after_mem_en", {31'b0, o_mem_en}, 32'd0);
   endtask

   vec_t vecs[17];
   vec_t hv;

   initial begin
      n_cmp = 0;
      n_err = 0;
      for (int i = 0; i < 256; i++) ram[i] = 32'h0;
      rst_n          = 1'b0;
      i_req_valid    = 1'b0;
      i_req_write    = 1'b0;
      i_req_size     = 2'd0;
      i_req_unsigned = 1'b0;
      i_req_addr     = 10'h0;
      i_req_wdata    = 32'h0;
      i_mem_data_in  = 32'h0;
      i_mem_ack      = 1'b0;

      //          wr    sz    un    addr    wdata         dly sel   dout          rdata
      vecs[0]  = '{1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, 0, 4'hF, 32'hDEADBEEF, 32'h0};
      vecs[1]  = '{1'b1, 2'd0, 1'b0, 10'h013, 32'h000000A5, 0, 4'h8, 32'hA5A5A5A5, 32'h0};
      vecs[2]  = '{1'b0, 2'd2, 1'b0, 10'h010, 32'h0,        0, 4'hF, 32'h0,        32'hA5ADBEEF};
      vecs[3]  = '{1'b0, 2'd0, 1'b0, 10'h011, 32'h0,        1, 4'h2, 32'h0,        32'hFFFFFFBE};
      vecs[4]  = '{1'b0, 2'd1, 1'b1, 10'h012, 32'h0,        0, 4'hC, 32'h0,        32'h0000A5AD};
      vecs[5]  = '{1'b1, 2'd2, 1'b0, 10'h020, 32'h80000000, 0, 4'hF, 32'h80000000, 32'h0};
      vecs[6]  = '{1'b0, 2'd0, 1'b0, 10'h023, 32'h0,        0, 4'h8, 32'h0,        32'hFFFFFF80};
      vecs[7]  = '{1'b0, 2'd0, 1'b1, 10'h023, 32'h0,        2, 4'h8, 32'h0,        32'h00000080};
      vecs[8]  = '{1'b1, 2'd0, 1'b0, 10'h022, 32'h1234567F, 0, 4'h4, 32'h7F7F7F7F, 32'h0};
      vecs[9]  = '{1'b0, 2'd0, 1'b0, 10'h022, 32'h0,        0, 4'h4, 32'h0,        32'h0000007F};
      vecs[10] = '{1'b0, 2'd2, 1'b1, 10'h020, 32'h0,        0, 4'hF, 32'h0,        32'h807F0000};
      vecs[11] = '{1'b1, 2'd2, 1'b0, 10'h030, 32'h80017FFF, 0, 4'hF, 32'h80017FFF, 32'h0};
      vecs[12] = '{1'b0, 2'd1, 1'b0, 10'h032, 32'h0,        0, 4'hC, 32'h0,        32'hFFFF8001};
      vecs[13] = '{1'b0, 2'd1, 1'b1, 10'h032, 32'h0,        0, 4'hC, 32'h0,        32'h00008001};
      vecs[14] = '{1'b0, 2'd1, 1'b0, 10'h030, 32'h0,        0, 4'h3, 32'h0,        32'h00007FFF};
      vecs[15] = '{1'b1, 2'd1, 1'b0, 10'h042, 32'hFFFF1234, 1, 4'hC, 32'h12341234, 32'h0};
      vecs[16] = '{1'b0, 2'd2, 1'b0, 10'h040, 32'h0,        0, 4'hF, 32'h0,        32'h12340000};

      // Reset state
      #1;
      chk("rst_ready", {31'b0, o_req_ready}, 32'd1);
      chk("rst_mem_en", {31'b0, o_mem_en}, 32'd0);
      chk("rst_resp_valid", {31'b0, o_resp_valid}, 32'd0);
      chk("rst_rdata", o_resp_rdata, 32'h0);
      chk("rst_sel", {28'b0, o_mem_sel}, 32'd0);
      chk("rst_mem_addr", {24'b0, o_mem_addr}, 32'd0);
      chk("rst_dout", o_mem_data_out, 32'h0);
      chk("rst_mem_write", {31'b0, o_mem_write}, 32'd0);
      chk("rst_err", {31'b0, o_resp_err}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) access(vecs[i], 1'b0);

      // Late ack (3 idle WAIT cycles) with req_valid held high throughout
      hv = '{1'b0, 2'd2, 1'b0, 10'h030, 32'h0, 3, 4'hF, 32'h0, 32'h80017FFF};
      access(hv, 1'b1);

`ifdef MEM_INITIATOR_MISALIGN_TRAP_EN
      fault_access(2'd2, 10'h011);
      fault_access(2'd1, 10'h031);
      fault_access(2'd3, 10'h020);
`else
      // Misaligned word is forced aligned; reserved size behaves as a word
      hv = '{1'b0, 2'd2, 1'b0, 10'h011, 32'h0, 0, 4'hF, 32'h0, 32'hA5ADBEEF};
      access(hv, 1'b0);
      hv = '{1'b0, 2'd1, 1'b0, 10'h031, 32'h0, 0, 4'h3, 32'h0, 32'h00007FFF};
      access(hv, 1'b0);
      hv = '{1'b0, 2'd3, 1'b0, 10'h022, 32'h0, 0, 4'hF, 32'h0, 32'h807F0000};
      access(hv, 1'b0);
`endif

      // Reset during WAIT, then a late ack that must be ignored
      @(negedge clk);
      i_req_valid = 1'b1;
      i_req_write = 1'b0;
      i_req_size  = 2'd2;
      i_req_addr  = 10'h010;
      @(negedge clk);
      i_req_valid = 1'b0;
      chk("rstmid_req_en", {31'b0, o_mem_en}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rstmid_mem_en", {31'b0, o_mem_en}, 32'd0);
      chk("rstmid_ready", {31'b0, o_req_ready}, 32'd1);
      chk("rstmid_sel", {28'b0, o_mem_sel}, 32'd0);
      @(negedge clk);
      rst_n         = 1'b1;
      i_mem_ack     = 1'b1;
      i_mem_data_in = 32'hCAFEF00D;
      @(negedge clk);
      i_mem_ack     = 1'b0;
      i_mem_data_in = 32'h0;
      chk("late_ack_valid", {31'b0, o_resp_valid}, 32'd0);
      chk("late_ack_ready", {31'b0, o_req_ready}, 32'd1);
      chk("late_ack_mem_en", {31'b0, o_mem_en}, 32'd0);
      chk("late_ack_rdata", o_resp_rdata, 32'h0);
      @(negedge clk);
      chk("late_ack_valid2", {31'b0, o_resp_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Load/store front end that drives the word-organised, byte-enabled on-chip RAM port: mem_en, mem_write, sel, ack.
- Accepts one byte-addressed load or store at a time from the core: LB/LH/LW/LBU/LHU/SB/SH/SW.
- Converts it into a single word access with byte-lane selects and replicated write data.
- Returns the lane-extracted, sign- or zero-extended read result to the core.

Parameters:
- ADDR_W, 10, byte-address width; bus word address is ADDR_W-2 bits (8 for the 1 KiB RAM).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request present
- req_ready  out  1  block can accept request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_unsigned  in  1  loads only: zero-extend instead of sign-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data (0 for stores)
- resp_err  out  1  access faulted (see Optional Feature)
- mem_addr  out  ADDR_W-2  word address
- mem_sel  out  4  byte-lane enables
- mem_data_out  out  32  write data to RAM
- mem_data_in  in  32  read data from RAM
- mem_en  out  1  access strobe
- mem_write  out  1  access is a write
- mem_ack  in  1  responder acknowledge; read data valid in the same cycle

Behaviour:
- States: IDLE, REQ, WAIT, RESP. Reset state is IDLE.
- Reset values: all outputs 0 except req_ready = 1. All request capture registers are cleared to 0.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, capture write, size, unsigned, addr and wdata, then go to REQ.
  - mem_ack is ignored in IDLE.
- REQ:
  - mem_en = 1 for exactly one cycle.
  - mem_write = captured write.
  - mem_addr = addr[ADDR_W-1:2].
  - Next state is WAIT.
- WAIT:
  - mem_en = 0; mem_addr, mem_sel, mem_data_out and mem_write hold their values.
  - Stay in WAIT until mem_ack = 1.
  - On ack, register the response and go to RESP.
  - Waiting has no bound, so a slower responder stalls the block indefinitely.
- RESP:
  - resp_valid = 1 for one cycle, with resp_rdata and resp_err stable.
  - Next state is IDLE.
- Latency: accept at edge N, mem_en high in cycle N+1, responder ack in cycle N+2, resp_valid in cycle N+3. Back-to-back throughput is one access per 4 cycles.
- mem_sel, where off = addr[1:0]:
  - byte: 4'b0001 << off
  - half: 4'b0011 << off
  - word: 4'b1111
- mem_data_out:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extraction:
  - byte: lane = mem_data_in[8*off +: 8]
  - half: lane = mem_data_in[16*addr[1] +: 16]
  - The lane is sign-extended from its MSB unless unsigned is set, in which case it is zero-extended.
  - word: mem_data_in passes through unchanged, and unsigned has no effect.
- Stores: resp_rdata = 0. The response is still produced after ack.
- Reset asserted mid-access: immediate return to IDLE with mem_en = 0 and the transaction discarded. A late ack from the responder is ignored because IDLE ignores mem_ack.
- req_size = 3: treated as a word access. With the optional feature enabled it faults instead.

Optional Feature:
- Macro: MEM_INITIATOR_MISALIGN_TRAP_EN.
- Enabled:
  - A half with addr[0] = 1, a word with addr[1:0] != 0, or size = 3 is faulted.
  - A faulted request goes IDLE -> RESP directly, with no mem_en.
  - resp_valid pulses one cycle after accept with resp_err = 1 and resp_rdata = 0.
- Disabled:
  - resp_err is tied to 0.
  - Misaligned offsets are forced aligned: half uses addr[1] only, word ignores addr[1:0].

Test Plan:
- SW addr 0x010 wdata 0xDEADBEEF -> mem_en one cycle with mem_addr 0x04, sel 4'b1111, mem_write 1; resp_valid 3 cycles after accept, rdata 0.
- SB addr 0x013 wdata 0x000000A5 -> sel 4'b1000, mem_data_out 0xA5A5A5A5. Then LW 0x010 -> rdata 0xA5ADBEEF.
- LB addr 0x013 after RAM word 0x80000000 -> rdata 0xFFFFFF80; LBU -> 0x00000080.
- LH addr 0x012 on word 0x8001_7FFF -> 0xFFFF8001; LHU -> 0x00008001; LH addr 0x010 -> 0x00007FFF.
- Responder acks 3 cycles late -> mem_en stays a single pulse, outputs held, and resp_valid comes the cycle after ack. req_valid held high during the access -> req_ready stays 0, no second capture.
- rst_n low in the WAIT cycle, then ack arrives -> no resp_valid, req_ready = 1. With the macro enabled, LW addr 0x011 -> no mem_en, resp_err 1 one cycle after accept.
